// File: rtl/data_mem_mmio.sv
// Data-side memory and MMIO block: word RAM, LED register, cycle counter and
// an 8N1 UART transmitter fed by a byte FIFO. ReadData is combinational.
module data_mem_mmio #(
    parameter int unsigned RAM_WORDS  = 64,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned BAUD_DIV   = 434
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemWrite,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        tx,
    output logic [7:0]  leds
);

    localparam int unsigned AW = $clog2(RAM_WORDS);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned BW = $clog2(BAUD_DIV);

    // Word addresses (byte address >> 2) of the peripheral registers
    localparam logic [29:0] ADDR_LED    = 30'h0400_0000;
    localparam logic [29:0] ADDR_TXDATA = 30'h0400_0001;
    localparam logic [29:0] ADDR_STATUS = 30'h0400_0002;
    localparam logic [29:0] ADDR_CYCLES = 30'h0400_0003;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_t;

    logic [31:0]   r_ram [RAM_WORDS];
    logic [7:0]    r_fifo [FIFO_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_ovf;
    logic [7:0]    r_leds;
    logic [31:0]   r_cycles;

    uart_state_t   r_state;
    logic [BW-1:0] r_baud;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          r_tx;

    logic [29:0]   w_word;
    logic [AW-1:0] w_ram_idx;
    logic          w_ram_sel;
    logic          w_led_sel;
    logic          w_txd_sel;
    logic          w_stat_sel;
    logic          w_cyc_sel;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_push_ok;
    logic          w_pop;
    logic          w_baud_end;
    logic          w_busy;
    logic [3:0]    w_cnt_sat;
    logic [7:0]    w_fifo_head;
    logic [31:0]   w_status;
    logic          w_unused;

    // Address decode; the byte-offset bits carry no meaning for word accesses
    assign w_word     = ALUResult[31:2];
    assign w_ram_idx  = ALUResult[AW+1:2];
    assign w_ram_sel  = (ALUResult[31:28] == 4'h0);
    assign w_led_sel  = (w_word == ADDR_LED);
    assign w_txd_sel  = (w_word == ADDR_TXDATA);
    assign w_stat_sel = (w_word == ADDR_STATUS);
    assign w_cyc_sel  = (w_word == ADDR_CYCLES);
    assign w_unused   = &{1'b0, ALUResult[1:0]};

    assign w_full      = (r_count == CW'(FIFO_DEPTH));
    assign w_empty     = (r_count == '0);
    assign w_push      = MemWrite & w_txd_sel;
    assign w_push_ok   = w_push & ~w_full;
    assign w_baud_end  = (r_baud == BW'(BAUD_DIV - 1));
    assign w_pop       = ~w_empty & ((r_state == S_IDLE) |
                                     ((r_state == S_STOP) & w_baud_end));
    assign w_busy      = (r_state != S_IDLE);
    assign w_fifo_head = r_fifo[r_rd_ptr];
    assign w_cnt_sat   = (32'(r_count) > 32'd15) ? 4'd15 : 4'(r_count);
    assign w_status    = {24'd0, w_cnt_sat, r_ovf, w_busy, w_empty, w_full};

    assign tx   = r_tx;
    assign leds = r_leds;

    always_comb begin
        ReadData = 32'd0;
        if (w_ram_sel)       ReadData = r_ram[w_ram_idx];
        else if (w_led_sel)  ReadData = {24'd0, r_leds};
        else if (w_stat_sel) ReadData = w_status;
        else if (w_cyc_sel)  ReadData = r_cycles;
    end

    // Storage arrays are intentionally not reset
    always_ff @(posedge clk) begin
        if (MemWrite && w_ram_sel) r_ram[w_ram_idx] <= WriteData;
        if (w_push_ok)             r_fifo[r_wr_ptr] <= WriteData[7:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)     r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            // Fullness is judged before any same-cycle pop
            if (w_push && w_full)               r_ovf <= 1'b1;
            else if (MemWrite && w_stat_sel)    r_ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_leds   <= 8'd0;
            r_cycles <= 32'd0;
        end else begin
            if (MemWrite && w_led_sel) r_leds <= WriteData[7:0];
            if (MemWrite && w_cyc_sel) r_cycles <= 32'd0;
            else                       r_cycles <= r_cycles + 32'd1;
        end
    end

    // UART transmitter; tx is updated on the same edge as the state change
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_baud  <= '0;
            r_bit   <= 3'd0;
            r_shift <= 8'd0;
            r_tx    <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_shift <= w_fifo_head;
                        r_baud  <= '0;
                        r_bit   <= 3'd0;
                        r_state <= S_START;
                        r_tx    <= 1'b0;
                    end else begin
                        r_tx <= 1'b1;
                    end
                end
                S_START: begin
                    if (w_baud_end) begin
                        r_baud  <= '0;
                        r_state <= S_DATA;
                        r_tx    <= r_shift[0];
                    end else begin
                        r_baud <= r_baud + BW'(1);
                    end
                end
                S_DATA: begin
                    if (w_baud_end) begin
                        r_baud  <= '0;
                        r_shift <= r_shift >> 1;
                        if (r_bit == 3'd7) begin
                            r_state <= S_STOP;
                            r_tx    <= 1'b1;
                        end else begin
                            r_bit <= r_bit + 3'd1;
                            r_tx  <= r_shift[1];
                        end
                    end else begin
                        r_baud <= r_baud + BW'(1);
                    end
                end
                S_STOP: begin
                    if (w_baud_end) begin
                        r_baud <= '0;
                        if (w_pop) begin
                            r_shift <= w_fifo_head;
                            r_bit   <= 3'd0;
                            r_state <= S_START;
                            r_tx    <= 1'b0;
                        end else begin
                            r_state <= S_IDLE;
                            r_tx    <= 1'b1;
                        end
                    end else begin
                        r_baud <= r_baud + BW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_mmio.sv
// Bench for data_mem_mmio: register/RAM checks plus a UART monitor that
// compares each decoded frame against a queue of expected bytes.
module tb_data_mem_mmio;

    localparam logic [31:0] A_LED    = 32'h1000_0000;
    localparam logic [31:0] A_TXDATA = 32'h1000_0004;
    localparam logic [31:0] A_STATUS = 32'h1000_0008;
    localparam logic [31:0] A_CYCLES = 32'h1000_000C;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] ALUResult = 32'd0;
    logic [31:0] WriteData = 32'd0;
    logic [31:0] ReadData;
    logic        tx;
    logic [7:0]  leds;

    int          n_checks = 0;
    int          n_errors = 0;
    int unsigned tb_cyc = 0;
    int          frames_done = 0;
    logic [7:0]  exp_q[$];
    int unsigned starts[$];

    data_mem_mmio #(.RAM_WORDS(64), .FIFO_DEPTH(8), .BAUD_DIV(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .MemWrite  (MemWrite),
        .ALUResult (ALUResult),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .tx        (tx),
        .leds      (leds)
    );

    always #5 clk = ~clk;
    always @(posedge clk) tb_cyc <= tb_cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        ALUResult = a;
        WriteData = d;
        MemWrite  = 1'b1;
        @(posedge clk);
        #1;
        MemWrite  = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] v);
        ALUResult = a;
        #1;
        v = ReadData;
    endtask

    function automatic logic [63:0] frame_bits(input logic [7:0] b);
        logic [63:0] f;
        f = '0;
        for (int i = 0; i < 40; i++) begin
            if (i < 4)        f[i] = 1'b0;
            else if (i >= 36) f[i] = 1'b1;
            else              f[i] = b[(i - 4) / 4];
        end
        return f;
    endfunction

    // UART monitor: samples tx once per cycle, 40 samples per frame
    initial begin : monitor
        logic [63:0] got;
        logic [7:0]  b;
        int unsigned st;
        bit          ok;
        forever begin
            @(negedge clk);
            if (rst && tx === 1'b0) begin
                got = '0;
                got[0] = tx;
                st = tb_cyc;
                ok = 1'b1;
                for (int i = 1; i < 40; i++) begin
                    @(negedge clk);
                    if (!rst) begin
                        ok = 1'b0;
                        break;
                    end
                    got[i] = tx;
                end
                if (ok) begin
                    starts.push_back(st);
                    if (exp_q.size() == 0) begin
                        check("unexpected_frame", 64'(exp_q.size()), 64'd1);
                    end else begin
                        b = exp_q.pop_front();
                        check("frame_bits", got, frame_bits(b));
                    end
                    frames_done++;
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [31:0] v;
        int unsigned wr;
        int          base;
        int          n;

        // Reset values, with reset applied mid-operation
        repeat (3) @(negedge clk);
        rst = 1'b1;
        do_write(A_LED, 32'h0000_015A);
        check("led_written", 64'(leds), 64'h5A);
        repeat (5) @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("rst_leds", 64'(leds), 64'h0);
        check("rst_tx", 64'(tx), 64'h1);
        rd(A_STATUS, v);
        check("rst_status", 64'(v), 64'h02);
        @(negedge clk);
        rst = 1'b1;
        rd(A_CYCLES, v);
        check("rst_cycles", 64'(v), 64'h0);

        // RAM, alias, peripherals and unmapped reads
        do_write(32'h0000_0010, 32'hDEAD_BEEF);
        rd(32'h0000_0010, v);
        check("ram_read", 64'(v), 64'hDEAD_BEEF);
        rd(32'h0000_0110, v);
        check("ram_alias", 64'(v), 64'hDEAD_BEEF);
        rd(32'h2000_0000, v);
        check("unmapped_2000", 64'(v), 64'h0);
        rd(32'h1000_0010, v);
        check("unmapped_1010", 64'(v), 64'h0);
        do_write(32'h0000_0014, 32'h1234_5678);
        rd(32'h0000_0014, v);
        check("ram_read2", 64'(v), 64'h1234_5678);
        rd(32'h0000_0010, v);
        check("ram_keep", 64'(v), 64'hDEAD_BEEF);
        do_write(A_LED, 32'hFFFF_FFA5);
        rd(A_LED, v);
        check("led_read", 64'(v), 64'hA5);
        check("led_port", 64'(leds), 64'hA5);
        rd(A_TXDATA, v);
        check("txdata_read", 64'(v), 64'h0);

        // Single frame
        starts.delete();
        base = frames_done;
        do_write(A_TXDATA, 32'h0000_00A5);
        exp_q.push_back(8'hA5);
        wr = tb_cyc;
        rd(A_STATUS, v);
        check("status_pushed", 64'(v), 64'h10);
        @(posedge clk); #1;
        rd(A_STATUS, v);
        check("status_busy", 64'(v), 64'h06);
        repeat (39) @(posedge clk);
        #1;
        rd(A_STATUS, v);
        check("busy_last_cycle", 64'(v[2]), 64'h1);
        @(posedge clk); #1;
        rd(A_STATUS, v);
        check("status_idle", 64'(v), 64'h02);
        check("frames_single", 64'(frames_done - base), 64'd1);
        if (starts.size() > 0) check("first_tx_low", 64'(starts[0]), 64'(wr + 1));
        else check("first_tx_low_seen", 64'(starts.size()), 64'd1);

        // FIFO full, overflow and back-to-back frames
        starts.delete();
        base = frames_done;
        for (int k = 0; k < 9; k++) begin
            do_write(A_TXDATA, 32'(8'h30 + k));
            exp_q.push_back(8'(8'h30 + k));
        end
        rd(A_STATUS, v);
        check("status_full", 64'(v), 64'h85);
        do_write(A_TXDATA, 32'h0000_00EE);
        rd(A_STATUS, v);
        check("status_ovf", 64'(v), 64'h8D);
        do_write(A_STATUS, 32'h0);
        rd(A_STATUS, v);
        check("status_ovf_clr", 64'(v), 64'h85);
        for (int t = 0; t < 600 && frames_done < base + 9; t++) @(posedge clk);
        #1;
        check("frames_burst", 64'(frames_done - base), 64'd9);
        check("burst_starts", 64'(starts.size()), 64'd9);
        for (int i = 1; i < starts.size(); i++)
            check("frame_gap", 64'(starts[i] - starts[i-1]), 64'd40);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        rd(A_STATUS, v);
        check("status_after_burst", 64'(v), 64'h02);

        // Cycle counter load
        do_write(A_CYCLES, 32'hFFFF_FFFF);
        rd(A_CYCLES, v);
        check("cycles_0", 64'(v), 64'd0);
        @(posedge clk); #1;
        rd(A_CYCLES, v);
        check("cycles_1", 64'(v), 64'd1);
        @(posedge clk); #1;
        rd(A_CYCLES, v);
        check("cycles_2", 64'(v), 64'd2);

        // Reset in the middle of DATA bit 3
        do_write(A_TXDATA, 32'h0000_0050);
        wr = tb_cyc;
        exp_q.push_back(8'h50);
        do_write(A_TXDATA, 32'h0000_0011);
        exp_q.push_back(8'h11);
        do_write(A_TXDATA, 32'h0000_0022);
        exp_q.push_back(8'h22);
        while (tb_cyc < wr + 18) @(posedge clk);
        #2;
        check("tx_bit3", 64'(tx), 64'h0);
        rst = 1'b0;
        #1;
        check("rst_async_tx", 64'(tx), 64'h1);
        rd(A_STATUS, v);
        check("rst_fifo_empty", 64'(v), 64'h02);
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        n = starts.size();
        repeat (100) @(posedge clk);
        #1;
        check("no_resume", 64'(starts.size()), 64'(n));
        check("tx_idle", 64'(tx), 64'h1);
        rd(A_STATUS, v);
        check("status_final", 64'(v), 64'h02);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
